// File: rtl/cnn_pkg.sv
// Shared types and constants for the OFM write path: FSM encoding and the
// byte/slot geometry of a packed 32-bit OFM word.
package cnn_pkg;

    localparam int SLOTS  = 4;
    localparam int BYTE_W = 8;
    localparam int WORD_W = SLOTS * BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } ofm_state_t;

    // Slot 0 is the most significant byte of the packed word.
    function automatic int slot_lsb(input int slot);
        return (SLOTS - 1 - slot) * BYTE_W;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requesting lane at or above ptr,
// wrapping modulo LANES. Purely combinational.
module rr_arbiter #(
    parameter int LANES = 4,
    parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES-1:0] req,
    input  logic [LW-1:0]    ptr,
    output logic [LANES-1:0] grant,
    output logic [LW-1:0]    grant_idx,
    output logic             grant_any
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int i = 0; i < LANES; i++) begin
            idx = int'(ptr) + i;
            if (idx >= LANES) begin
                idx = idx - LANES;
            end
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = LW'(idx);
            end
        end
    end

endmodule

// File: rtl/ofm_wr_sched.sv
// OFM write scheduler: gathers bytes from LANES requesters round-robin, packs
// four per word and writes DEPTH words starting at BASE.
module ofm_wr_sched
    import cnn_pkg::*;
#(
    parameter int          DEPTH = 128,
    parameter int          LANES = 4,
    parameter logic [31:0] BASE  = 32'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                flush,
    input  logic [LANES-1:0]    req_valid,
    input  logic [8*LANES-1:0]  req_data,
    output logic [LANES-1:0]    req_ready,
    output logic                ofm_wr,
    output logic [31:0]         ofm_addr,
    output logic [31:0]         ofm_wr_data,
    output logic                busy,
    output logic                done
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(SLOTS);

    ofm_state_t        state_reg, state_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [SW-1:0]     slot_reg, slot_next;
    logic [LW-1:0]     rr_reg, rr_next;
    logic [WORD_W-1:0] pack_reg, pack_next;

    logic              ofm_wr_reg;
    logic [31:0]       ofm_addr_reg;
    logic [31:0]       ofm_data_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [BYTE_W-1:0] lane_byte [LANES];
    logic [LANES-1:0]  arb_req;
    logic [LANES-1:0]  grant;
    logic [LW-1:0]     grant_idx;
    logic              grant_any;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_byte[gi] = req_data[BYTE_W*gi +: BYTE_W];
        end
    endgenerate

    // Gating the requests keeps the grant, and hence req_ready, zero outside COLLECT.
    assign arb_req = (state_reg == ST_COLLECT) ? req_valid : '0;

    rr_arbiter #(
        .LANES (LANES),
        .LW    (LW)
    ) u_arb (
        .req       (arb_req),
        .ptr       (rr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Ready must answer valid in the same cycle to sustain 4 bytes per 5 cycles.
    assign req_ready   = grant;
    assign ofm_wr      = ofm_wr_reg;
    assign ofm_addr    = ofm_addr_reg;
    assign ofm_wr_data = ofm_data_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        slot_next  = slot_reg;
        rr_next    = rr_reg;
        pack_next  = pack_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_COLLECT;
                    count_next = '0;
                    slot_next  = '0;
                    rr_next    = '0;
                    pack_next  = '0;
                end
            end
            ST_COLLECT: begin
                if (grant_any) begin
                    pack_next[slot_lsb(int'(slot_reg)) +: BYTE_W] = lane_byte[grant_idx];
                    slot_next = slot_reg + SW'(1);
                    rr_next   = (grant_idx == LW'(LANES - 1)) ? '0 : grant_idx + LW'(1);
                end
                // A grant coinciding with flush is packed before the word goes out.
                if ((grant_any && (slot_reg == SW'(SLOTS - 1) || flush)) ||
                    (flush && slot_reg != '0)) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                count_next = count_reg + CW'(1);
                slot_next  = '0;
                pack_next  = '0;
                state_next = (count_reg == CW'(DEPTH - 1)) ? ST_DONE : ST_COLLECT;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            slot_reg     <= '0;
            rr_reg       <= '0;
            pack_reg     <= '0;
            ofm_wr_reg   <= 1'b0;
            ofm_addr_reg <= '0;
            ofm_data_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            slot_reg   <= slot_next;
            rr_reg     <= rr_next;
            pack_reg   <= pack_next;
            ofm_wr_reg <= (state_next == ST_WRITE);
            if (state_reg == ST_COLLECT && state_next == ST_WRITE) begin
                ofm_addr_reg <= BASE + 32'(count_reg);
                ofm_data_reg <= pack_next;
            end
            busy_reg <= (state_next == ST_COLLECT) || (state_next == ST_WRITE);
            done_reg <= (state_next == ST_DONE);
        end
    end

endmodule

// File: tb/tb_ofm_wr_sched.sv
// Directed bench for ofm_wr_sched (DEPTH=4): packing, round-robin order,
// flush, start-ignore, pass completion and mid-pass reset.
module tb_ofm_wr_sched;

    localparam int LANES = 4;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               flush = 1'b0;
    logic [LANES-1:0]   req_valid = '0;
    logic [8*LANES-1:0] req_data = '0;
    logic [LANES-1:0]   req_ready;
    logic               ofm_wr;
    logic [31:0]        ofm_addr;
    logic [31:0]        ofm_wr_data;
    logic               busy;
    logic               done;

    int vectors = 0;
    int errors  = 0;
    int edge_cnt = 0;

    int          g_lane[$];
    int          g_edge[$];
    logic [31:0] w_addr[$];
    logic [31:0] w_data[$];
    int          w_edge[$];

    ofm_wr_sched #(
        .DEPTH (DEPTH),
        .LANES (LANES),
        .BASE  (32'd0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .ofm_wr      (ofm_wr),
        .ofm_addr    (ofm_addr),
        .ofm_wr_data (ofm_wr_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Log every handshake and write with the index of the edge that sampled it.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    g_lane.push_back(k);
                    g_edge.push_back(edge_cnt);
                end
            end
            if (ofm_wr) begin
                w_addr.push_back(ofm_addr);
                w_data.push_back(ofm_wr_data);
                w_edge.push_back(edge_cnt);
                $display("write addr=%0d data=%08h", ofm_addr, ofm_wr_data);
            end
        end
        edge_cnt++;
    end

    task automatic clear_logs();
        g_lane.delete();
        g_edge.delete();
        w_addr.delete();
        w_data.delete();
        w_edge.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input int lane, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        req_valid = '0;
        req_valid[lane] = 1'b1;
        req_data[8*lane +: 8] = b;
        for (int t = 0; t < 20 && !ok; t++) begin
            #1;
            if (req_ready[lane]) ok = 1'b1;
            @(negedge clk);
        end
        req_valid = '0;
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL send_byte lane %0d byte %02h: req_ready=0 for 20 cycles, required 1", lane, b);
        end
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int t = 0; t < budget && w_addr.size() < n; t++) @(negedge clk);
        vectors++;
        if (w_addr.size() < n) begin
            errors++;
            $display("FAIL wait_writes: got %0d writes, required %0d", w_addr.size(), n);
        end
    endtask

    task automatic check_write(input int idx, input logic [31:0] ea, input logic [31:0] ed);
        vectors++;
        if (idx >= w_addr.size()) begin
            errors++;
            $display("FAIL write%0d: missing, required addr=%0d data=%08h", idx, ea, ed);
        end else if (w_addr[idx] !== ea || w_data[idx] !== ed) begin
            errors++;
            $display("FAIL write%0d: addr=%0d data=%08h, required addr=%0d data=%08h",
                     idx, w_addr[idx], w_data[idx], ea, ed);
        end else begin
            $display("vector write%0d addr=%0d data=%08h ok", idx, ea, ed);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        vectors++;
        if (ofm_wr !== 1'b0 || ofm_addr !== 32'd0 || ofm_wr_data !== 32'd0 ||
            req_ready !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s: wr=%b addr=%h data=%h ready=%b busy=%b done=%b, required all 0",
                     tag, ofm_wr, ofm_addr, ofm_wr_data, req_ready, busy, done);
        end else begin
            $display("vector %s outputs zero ok", tag);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        @(negedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (req_ready !== 4'd0) begin
            errors++;
            $display("FAIL idle_ready: req_ready=%b, required 0000", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_single_lane();
        clear_logs();
        pulse_start();
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: busy=%b, required 1", busy);
        end
        send_byte(0, 8'h11);
        send_byte(0, 8'h22);
        send_byte(0, 8'h33);
        send_byte(0, 8'h44);
        wait_writes(1, 10);
        check_write(0, 32'd0, 32'h11223344);
        // The write occupies the fifth cycle of the word, counted from the first accept.
        vectors++;
        if (w_edge.size() < 1 || g_edge.size() < 1 || w_edge[0] - g_edge[0] != 4) begin
            errors++;
            $display("FAIL write_latency: %0d edges, required 4",
                     (w_edge.size() > 0 && g_edge.size() > 0) ? w_edge[0] - g_edge[0] : -1);
        end
    endtask

    task automatic test_round_robin();
        bit order_ok;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
        pulse_start();
        req_data  = 32'hA3A2A1A0;
        req_valid = 4'hF;
        wait_writes(2, 30);
        order_ok = (g_lane.size() >= 8);
        for (int i = 0; i < 8 && order_ok; i++) begin
            if (g_lane[i] != (i % 4)) order_ok = 1'b0;
        end
        vectors++;
        if (!order_ok) begin
            errors++;
            $display("FAIL rr_order: grants=%p, required 0,1,2,3,0,1,2,3", g_lane);
        end
        check_write(0, 32'd0, 32'hA0A1A2A3);
        check_write(1, 32'd1, 32'hA0A1A2A3);
    endtask

    task automatic test_done_depth();
        int gcount;
        for (int t = 0; t < 40 && !done; t++) @(negedge clk);
        check_write(2, 32'd2, 32'hA0A1A2A3);
        check_write(3, 32'd3, 32'hA0A1A2A3);
        vectors++;
        if (done !== 1'b1 || w_edge.size() != 4 || edge_cnt != w_edge[3] + 1) begin
            errors++;
            $display("FAIL done_timing: done=%b writes=%0d edge=%0d, required done=1 4 writes one edge after last write",
                     done, w_edge.size(), edge_cnt);
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_done: busy=%b, required 0", busy);
        end
        gcount = g_lane.size();
        for (int t = 0; t < 5; t++) begin
            #1;
            vectors++;
            if (req_ready !== 4'd0 || ofm_wr !== 1'b0 || done !== 1'b1) begin
                errors++;
                $display("FAIL done_quiet: ready=%b wr=%b done=%b, required 0000 0 1",
                         req_ready, ofm_wr, done);
            end
            @(negedge clk);
        end
        vectors++;
        if (g_lane.size() != gcount || w_addr.size() != 4) begin
            errors++;
            $display("FAIL done_accepts: grants=%0d writes=%0d, required %0d and 4",
                     g_lane.size(), w_addr.size(), gcount);
        end
        req_valid = '0;
    endtask

    task automatic test_flush();
        start = 1'b1;
        #1;
        vectors++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_sticky: done=%b, required 1", done);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart: done=%b busy=%b, required 0 1", done, busy);
        end
        @(negedge clk);
        clear_logs();
        send_byte(0, 8'h55);
        send_byte(0, 8'h66);
        flush = 1'b1;
        repeat (5) @(negedge clk);
        flush = 1'b0;
        vectors++;
        if (w_addr.size() != 1) begin
            errors++;
            $display("FAIL flush_count: writes=%0d, required 1", w_addr.size());
        end
        check_write(0, 32'd0, 32'h55660000);
        send_byte(3, 8'h01);
        send_byte(3, 8'h02);
        send_byte(3, 8'h03);
        send_byte(3, 8'h04);
        wait_writes(2, 10);
        check_write(1, 32'd1, 32'h01020304);
        flush = 1'b1;
        send_byte(1, 8'h77);
        flush = 1'b0;
        wait_writes(3, 10);
        check_write(2, 32'd2, 32'h77000000);
    endtask

    task automatic test_start_ignored();
        send_byte(2, 8'hC1);
        send_byte(2, 8'hC2);
        pulse_start();
        send_byte(2, 8'hC3);
        send_byte(2, 8'hC4);
        wait_writes(4, 10);
        check_write(3, 32'd3, 32'hC1C2C3C4);
        repeat (2) @(negedge clk);
        vectors++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored_done: done=%b, required 1", done);
        end
    endtask

    task automatic test_reset_midpass();
        pulse_start();
        clear_logs();
        for (int i = 0; i < 14; i++) send_byte(i % 4, 8'(i + 1));
        vectors++;
        if (w_addr.size() != 3) begin
            errors++;
            $display("FAIL pre_reset_writes: writes=%0d, required 3", w_addr.size());
        end
        req_valid = 4'hF;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midpass_reset");
        repeat (3) @(negedge clk);
        req_valid = '0;
        vectors++;
        if (w_addr.size() != 3) begin
            errors++;
            $display("FAIL reset_no_write: writes=%0d, required 3", w_addr.size());
        end
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
        pulse_start();
        send_byte(0, 8'hDE);
        send_byte(0, 8'hAD);
        send_byte(0, 8'hBE);
        send_byte(0, 8'hEF);
        wait_writes(1, 10);
        check_write(0, 32'd0, 32'hDEADBEEF);
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_round_robin();
        test_done_depth();
        test_flush();
        test_start_ignored();
        test_reset_midpass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ofm_wr_sched.md
OFM_WR_SCHED -- requirements
Module: ofm_wr_sched

Interface
REQ-001 Parameter: DEPTH, 128, number of 32-bit OFM words per pass.
REQ-002 Parameter: LANES, 4, number of byte requesters.
REQ-003 Parameter: BASE, 0, first OFM word address written.
REQ-004 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: start  in  1  one-cycle pulse that begins a pass.
REQ-007 Port: flush  in  1  level; forces a partially filled word to be written.
REQ-008 Port: req_valid  in  LANES  per-lane byte-available flag.
REQ-009 Port: req_data  in  8*LANES  per-lane byte; lane k occupies bits [8k+7:8k].
REQ-010 Port: req_ready  out  LANES  per-lane accept; a byte transfers when valid and ready are both high at a rising edge.
REQ-011 Port: ofm_wr  out  1  OFM write strobe.
REQ-012 Port: ofm_addr  out  32  OFM word address.
REQ-013 Port: ofm_wr_data  out  32  packed word; byte slot 0 in [31:24], slot 3 in [7:0].
REQ-014 Port: busy  out  1  high from start acceptance until done.
REQ-015 Port: done  out  1  sticky; high once DEPTH words have been written.

Function
REQ-016 The FSM SHALL have states IDLE, COLLECT, WRITE and DONE.
REQ-017 IDLE -> COLLECT on start; the word counter, slot pointer, RR pointer and pack buffer SHALL clear.
REQ-018 DONE -> COLLECT on start, with the same clearing; done SHALL drop in the cycle after start.
REQ-019 In COLLECT, a round-robin arbiter SHALL grant exactly one valid lane per cycle, searching from the RR pointer upward modulo LANES.
REQ-020 req_ready SHALL be one-hot on the granted lane in COLLECT and all-zero in every other state.
REQ-021 After a grant to lane k, the RR pointer SHALL become (k+1) mod LANES.
REQ-022 An accepted byte SHALL be stored in the slot given by the slot pointer (0..3); the pointer SHALL then increment.
REQ-023 Accepting the byte for slot 3 SHALL move the FSM to WRITE in the next cycle.
REQ-024 If flush is high in COLLECT with a slot pointer of 1..3, the FSM SHALL go to WRITE and unfilled slots SHALL be 0x00; flush SHALL be ignored at a slot pointer of 0.
REQ-025 If flush and a grant coincide, the byte SHALL be accepted first and then the word SHALL be written.
REQ-026 WRITE SHALL last exactly one cycle, with ofm_wr=1, ofm_addr=BASE+count and ofm_wr_data equal to the pack buffer.
REQ-027 Outputs SHALL come from registers; ofm_wr_data and ofm_addr SHALL stay stable while ofm_wr is high.
REQ-028 After WRITE, count SHALL increment and the slot pointer SHALL clear.
REQ-029 If count was DEPTH-1, the FSM SHALL enter DONE; otherwise it SHALL return to COLLECT.
REQ-030 Throughput SHALL be 4 bytes per 5 cycles when any lane is always valid.
REQ-031 start in COLLECT or WRITE SHALL be ignored.
REQ-032 In DONE, ofm_wr SHALL stay 0 and no bytes SHALL be accepted.

Reset
REQ-033 When rst_n is low, the FSM SHALL be IDLE and all outputs SHALL be 0: ofm_wr, ofm_addr, ofm_wr_data, req_ready, busy and done.
REQ-034 Reset assertion mid-pass SHALL abort immediately, dropping any partial word, with no write issued.
REQ-035 After reset, the RR pointer SHALL be 0.

Structure
REQ-036 The FSM state enum, the slot count (4) and the byte width (8) SHALL be defined in the shared package cnn_pkg.
REQ-037 The arbiter SHALL be a separate sub-module, rr_arbiter (LANES-wide, with a pointer input and one-hot grant output).

Verification
REQ-038 Reset, then start, with lane 0 only valid (data 0x11,0x22,0x33,0x44) -> one write at addr 0 with data 0x11223344, five cycles after the first accept.
REQ-039 All 4 lanes valid with bytes 0xA0+k -> grants ordered lanes 0,1,2,3; word 0xA0A1A2A3; the next word's grants restart at lane 0.
REQ-040 DEPTH=4, continuous traffic -> addrs 0..3 written; done=1 in the cycle after the 4th WRITE; busy=0; req_ready stays 0 afterwards.
REQ-041 Two bytes 0x55,0x66 accepted, then flush -> write of 0x55660000; the next word fills from slot 0.
REQ-042 rst_n low after 2 bytes of word 3 -> no write, all outputs 0; after restart, the first write is to addr 0.
REQ-043 Start pulsed during COLLECT -> ignored; count continues unchanged.
